// File: rtl/axis_i2s2_tx.sv
// AXI-Stream stereo sample sink driving an I2S transmit line (Pmod I2S2 DAC).
// Generates SCLK = clk/4 and LRCK = clk/256 from a free-running frame counter;
// one complete L/R packet is double-buffered and loaded at each frame boundary.
module axis_i2s2_tx #(
    parameter int unsigned DATA_WIDTH         = 24,
    parameter int unsigned UNDERRUN_CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         s_axis_data,
    input  logic                          s_axis_valid,
    output logic                          s_axis_ready,
    input  logic                          s_axis_last,
    output logic                          tx_sclk,
    output logic                          tx_lrck,
    output logic                          tx_sdout,
    output logic                          underrun,
    output logic [UNDERRUN_CNT_WIDTH-1:0] underrun_count
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LOAD = 8'hFF;

    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          full_q, full_d;
    logic                          have_left_q, have_left_d;
    logic [DATA_WIDTH-1:0]         l_buf_q, l_buf_d;
    logic [DATA_WIDTH-1:0]         r_buf_q, r_buf_d;
    logic [DATA_WIDTH-1:0]         l_tx_q, l_tx_d;
    logic [DATA_WIDTH-1:0]         r_tx_q, r_tx_d;
    logic                          sclk_q, sclk_d;
    logic                          lrck_q, lrck_d;
    logic                          sdout_q, sdout_d;
    logic                          underrun_q, underrun_d;
    logic [UNDERRUN_CNT_WIDTH-1:0] ucnt_q, ucnt_d;

    logic                          accept;
    logic                          load;
    logic [DATA_WIDTH-1:0]         chan;
    logic [DATA_WIDTH:0]           chan_sh;

    // Ready only reflects the registered buffer-full flag.
    assign s_axis_ready   = ~full_q;
    assign tx_sclk        = sclk_q;
    assign tx_lrck        = lrck_q;
    assign tx_sdout       = sdout_q;
    assign underrun       = underrun_q;
    assign underrun_count = ucnt_q;

    // Next-state: frame counter, input buffering, frame load and serializer.
    always_comb begin
        cnt_d       = cnt_q + 8'd1;
        full_d      = full_q;
        have_left_d = have_left_q;
        l_buf_d     = l_buf_q;
        r_buf_d     = r_buf_q;
        l_tx_d      = l_tx_q;
        r_tx_d      = r_tx_q;
        underrun_d  = 1'b0;
        ucnt_d      = ucnt_q;

        accept = s_axis_valid & ~full_q;
        load   = (cnt_q == CNT_LOAD);

        // Load decision uses the pre-accept full flag, so a packet completing
        // on the load cycle is kept for the following frame.
        if (load) begin
            if (full_q) begin
                l_tx_d = l_buf_q;
                r_tx_d = r_buf_q;
                full_d = 1'b0;
            end else begin
                l_tx_d     = '0;
                r_tx_d     = '0;
                underrun_d = 1'b1;
                if (~&ucnt_q) begin
                    ucnt_d = ucnt_q + UNDERRUN_CNT_WIDTH'(1);
                end
            end
        end

        // A lone right word plays against a silent left channel.
        if (accept) begin
            if (s_axis_last) begin
                r_buf_d     = s_axis_data;
                full_d      = 1'b1;
                have_left_d = 1'b0;
                if (!have_left_q) begin
                    l_buf_d = '0;
                end
            end else begin
                l_buf_d     = s_axis_data;
                have_left_d = 1'b1;
            end
        end

        // Slot k carries S[DATA_WIDTH-k]; the left shift by k brings that bit
        // to position DATA_WIDTH and naturally yields 0 for k=0 and k>DATA_WIDTH.
        chan    = cnt_q[7] ? r_tx_q : l_tx_q;
        chan_sh = {1'b0, chan} << cnt_q[6:2];
        sclk_d  = cnt_q[1];
        lrck_d  = cnt_q[7];
        sdout_d = chan_sh[DATA_WIDTH];
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            full_q      <= 1'b0;
            have_left_q <= 1'b0;
            l_buf_q     <= '0;
            r_buf_q     <= '0;
            l_tx_q      <= '0;
            r_tx_q      <= '0;
            sclk_q      <= 1'b0;
            lrck_q      <= 1'b0;
            sdout_q     <= 1'b0;
            underrun_q  <= 1'b0;
            ucnt_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            have_left_q <= have_left_d;
            l_buf_q     <= l_buf_d;
            r_buf_q     <= r_buf_d;
            l_tx_q      <= l_tx_d;
            r_tx_q      <= r_tx_d;
            sclk_q      <= sclk_d;
            lrck_q      <= lrck_d;
            sdout_q     <= sdout_d;
            underrun_q  <= underrun_d;
            ucnt_q      <= ucnt_d;
        end
    end

endmodule

// File: tb/tb_axis_i2s2_tx.sv
// Scoreboard bench for axis_i2s2_tx: packets pushed on accept, frames decoded
// from tx_sdout and popped for comparison.
module tb_axis_i2s2_tx;

    localparam int DW = 24;
    localparam int UW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          tx_sclk, tx_lrck, tx_sdout, underrun;
    logic [UW-1:0] underrun_count;

    logic          sat_valid = 1'b0;
    logic          sat_ready, sat_sclk, sat_lrck, sat_sdout, sat_underrun;
    logic [2:0]    sat_count;

    axis_i2s2_tx #(.DATA_WIDTH(DW), .UNDERRUN_CNT_WIDTH(UW)) dut (
        .clk(clk), .rst(rst), .s_axis_data(s_data), .s_axis_valid(s_valid),
        .s_axis_ready(s_ready), .s_axis_last(s_last), .tx_sclk(tx_sclk),
        .tx_lrck(tx_lrck), .tx_sdout(tx_sdout), .underrun(underrun),
        .underrun_count(underrun_count));

    axis_i2s2_tx #(.DATA_WIDTH(DW), .UNDERRUN_CNT_WIDTH(3)) dut_sat (
        .clk(clk), .rst(rst), .s_axis_data(s_data), .s_axis_valid(sat_valid),
        .s_axis_ready(sat_ready), .s_axis_last(s_last), .tx_sclk(sat_sclk),
        .tx_lrck(sat_lrck), .tx_sdout(sat_sdout), .underrun(sat_underrun),
        .underrun_count(sat_count));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } frame_t;

    int       n_cmp = 0;
    int       n_err = 0;
    logic [7:0] mcnt = 8'd0;
    frame_t   sb[$];
    logic [DW-1:0] pend_l = '0;
    bit       have_l = 1'b0;
    logic [7:0] acc_cnt;
    logic     sd[256];
    logic     sc[256];
    logic     lr[256];
    logic     ur[256];

    // Reference frame counter: value of the DUT counter during the current cycle.
    always @(posedge clk) begin
        if (rst) mcnt <= 8'd0;
        else     mcnt <= mcnt + 8'd1;
    end

    task automatic wait_cnt(input logic [7:0] target);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (mcnt == target) return;
        end
        n_cmp++; n_err++;
        $display("FAIL wait_cnt: counter never reached %0d", target);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        have_l = 1'b0;
        sb.delete();
    endtask

    // Present one word, wait (bounded) for ready, record the accept cycle.
    task automatic send(input logic [DW-1:0] data, input logic last);
        @(negedge clk);
        s_data = data; s_last = last; s_valid = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (s_ready) begin
                acc_cnt = mcnt;
                @(posedge clk);
                #1 s_valid = 1'b0;
                if (!last) begin
                    pend_l = data; have_l = 1'b1;
                end else begin
                    sb.push_back({(have_l ? pend_l : {DW{1'b0}}), data});
                    have_l = 1'b0;
                end
                return;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        n_cmp++; n_err++;
        $display("FAIL send: word %h never accepted", data);
    endtask

    // Capture one frame of outputs; index i holds outputs derived from cnt=i.
    task automatic capture();
        bit found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (mcnt == 8'd1) found = 1'b1;
        end
        if (!found) begin
            n_cmp++; n_err++;
            $display("FAIL capture: frame start not reached");
        end
        for (int i = 0; i < 256; i++) begin
            if (i != 0) @(negedge clk);
            sd[i] = tx_sdout; sc[i] = tx_sclk; lr[i] = tx_lrck; ur[i] = underrun;
        end
    endtask

    function automatic frame_t decode();
        frame_t f;
        f = '0;
        for (int k = 1; k <= DW; k++) begin
            f.l[DW-k] = sd[k*4 + 2];
            f.r[DW-k] = sd[128 + k*4 + 2];
        end
        return f;
    endfunction

    function automatic int unused_slot_ones();
        int n = 0;
        for (int i = 0; i < 256; i++) begin
            int k = (i >> 2) & 31;
            if ((k == 0 || k > DW) && sd[i] !== 1'b0) n++;
        end
        return n;
    endfunction

    function automatic int lrck_errs();
        int n = 0;
        for (int i = 0; i < 256; i++) if (lr[i] !== ((i >> 7) & 1)) n++;
        return n;
    endfunction

    function automatic int sd_ones();
        int n = 0;
        for (int i = 0; i < 256; i++) if (sd[i] !== 1'b0) n++;
        return n;
    endfunction

    task automatic test_reset();
        int e;
        do_reset(2);
        wait_cnt(8'd10);
        send(24'hABCDEF, 1'b0);
        send(24'h123456, 1'b1);
        wait_cnt(8'd100);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({tx_sclk, tx_lrck, tx_sdout, underrun} !== 4'b0) begin
            n_err++; $display("FAIL reset_outs: got %b want 0000", {tx_sclk, tx_lrck, tx_sdout, underrun});
        end
        n_cmp++;
        if (underrun_count !== '0) begin
            n_err++; $display("FAIL reset_count: got %0d want 0", underrun_count);
        end
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %b want 1", s_ready);
        end
        rst = 1'b0; have_l = 1'b0; sb.delete();
        capture();
        e = lrck_errs();
        n_cmp++;
        if (e != 0) begin
            n_err++; $display("FAIL reset_frame_timing: %0d lrck errors want 0", e);
        end
        e = sd_ones();
        n_cmp++;
        if (e != 0) begin
            n_err++; $display("FAIL reset_sdout: %0d nonzero samples want 0", e);
        end
        n_cmp++;
        if (ur[255] !== 1'b1 || ur[100] !== 1'b0) begin
            n_err++; $display("FAIL reset_underrun: got ur[255]=%b ur[100]=%b want 1,0", ur[255], ur[100]);
        end
    endtask

    task automatic test_single_packet();
        frame_t exp_f, got_f;
        int e;
        wait_cnt(8'd10);
        send(24'h800001, 1'b0);
        send(24'h7FFFFE, 1'b1);
        capture();
        got_f = decode();
        exp_f = (sb.size() != 0) ? sb.pop_front() : '0;
        n_cmp++;
        if (got_f.l !== exp_f.l) begin
            n_err++; $display("FAIL single_left: got %h want %h", got_f.l, exp_f.l);
        end
        n_cmp++;
        if (got_f.r !== exp_f.r) begin
            n_err++; $display("FAIL single_right: got %h want %h", got_f.r, exp_f.r);
        end
        e = unused_slot_ones();
        n_cmp++;
        if (e != 0) begin
            n_err++; $display("FAIL single_unused_slots: %0d ones want 0", e);
        end
        e = lrck_errs();
        n_cmp++;
        if (e != 0) begin
            n_err++; $display("FAIL single_lrck: %0d errors want 0", e);
        end
    endtask

    task automatic test_back_to_back();
        frame_t exp_f, got_f;
        logic [7:0] bl_cnt;
        wait_cnt(8'd10);
        send(24'h0F0F0F, 1'b0);
        send(24'hF0F0F0, 1'b1);
        fork
            capture();
            begin
                send(24'h5A5A5A, 1'b0);
                bl_cnt = acc_cnt;
                send(24'hA5A5A5, 1'b1);
            end
        join
        n_cmp++;
        if (bl_cnt !== 8'd0) begin
            n_err++; $display("FAIL b2b_accept_cycle: got cnt %0d want 0", bl_cnt);
        end
        got_f = decode();
        exp_f = (sb.size() != 0) ? sb.pop_front() : '0;
        n_cmp++;
        if (got_f !== exp_f) begin
            n_err++; $display("FAIL b2b_first: got %h want %h", got_f, exp_f);
        end
        n_cmp++;
        if (ur[255] !== 1'b0) begin
            n_err++; $display("FAIL b2b_no_underrun: got %b want 0", ur[255]);
        end
        capture();
        got_f = decode();
        exp_f = (sb.size() != 0) ? sb.pop_front() : '0;
        n_cmp++;
        if (got_f !== exp_f) begin
            n_err++; $display("FAIL b2b_second: got %h want %h", got_f, exp_f);
        end
    endtask

    task automatic test_misframe();
        frame_t exp_f, got_f;
        wait_cnt(8'd10);
        send(24'h111111, 1'b0);
        send(24'h222222, 1'b0);
        send(24'h333333, 1'b1);
        capture();
        got_f = decode();
        exp_f = (sb.size() != 0) ? sb.pop_front() : '0;
        n_cmp++;
        if (got_f !== exp_f) begin
            n_err++; $display("FAIL misframe_overwrite: got %h want %h", got_f, exp_f);
        end
        wait_cnt(8'd10);
        send(24'h444444, 1'b1);
        capture();
        got_f = decode();
        exp_f = (sb.size() != 0) ? sb.pop_front() : '0;
        n_cmp++;
        if (got_f !== exp_f) begin
            n_err++; $display("FAIL misframe_lone_right: got %h want %h", got_f, exp_f);
        end
    endtask

    task automatic test_clock_shape();
        frame_t exp_f, got_f;
        int rises = 0, bad_sd = 0, bad_lr = 0;
        wait_cnt(8'd10);
        send(24'hC3C3C3, 1'b0);
        send(24'h3C3C3C, 1'b1);
        capture();
        got_f = decode();
        exp_f = (sb.size() != 0) ? sb.pop_front() : '0;
        n_cmp++;
        if (got_f !== exp_f) begin
            n_err++; $display("FAIL shape_data: got %h want %h", got_f, exp_f);
        end
        for (int i = 1; i < 256; i++) begin
            bit fall = (sc[i-1] === 1'b1) && (sc[i] === 1'b0);
            if (sc[i-1] === 1'b0 && sc[i] === 1'b1) rises++;
            if (sd[i] !== sd[i-1] && !fall) bad_sd++;
            if (lr[i] !== lr[i-1] && !fall) bad_lr++;
        end
        n_cmp++;
        if (rises != 64) begin
            n_err++; $display("FAIL shape_sclk_rises: got %0d want 64", rises);
        end
        n_cmp++;
        if (bad_sd != 0) begin
            n_err++; $display("FAIL shape_sdout_edges: %0d off-edge changes want 0", bad_sd);
        end
        n_cmp++;
        if (bad_lr != 0) begin
            n_err++; $display("FAIL shape_lrck_edges: %0d off-edge changes want 0", bad_lr);
        end
    endtask

    task automatic test_starvation();
        int pulses = 0, misplaced = 0, ones = 0;
        do_reset(1);
        for (int f = 0; f < 5; f++) begin
            capture();
            for (int i = 0; i < 256; i++) begin
                if (ur[i] === 1'b1) begin
                    pulses++;
                    if (i != 255) misplaced++;
                end
            end
            ones += sd_ones();
        end
        n_cmp++;
        if (pulses != 5 || misplaced != 0) begin
            n_err++; $display("FAIL starve_pulses: got %0d (%0d misplaced) want 5 (0)", pulses, misplaced);
        end
        n_cmp++;
        if (ones != 0) begin
            n_err++; $display("FAIL starve_sdout: %0d nonzero samples want 0", ones);
        end
        n_cmp++;
        if (underrun_count !== 16'd5) begin
            n_err++; $display("FAIL starve_count: got %0d want 5", underrun_count);
        end
        n_cmp++;
        if (sat_count !== 3'd5) begin
            n_err++; $display("FAIL starve_sat_count5: got %0d want 5", sat_count);
        end
        repeat (4) capture();
        n_cmp++;
        if (underrun_count !== 16'd9) begin
            n_err++; $display("FAIL starve_count9: got %0d want 9", underrun_count);
        end
        n_cmp++;
        if (sat_count !== 3'd7) begin
            n_err++; $display("FAIL starve_saturate: got %0d want 7", sat_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_misframe();
        test_clock_shape();
        test_starvation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
